reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port architectural register file for the next-generation RISC-V core. It supports a configurable number of read and write ports, optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. A per-register busy scoreboard lets issue logic mark a destination as pending and lets writeback clear it. It replaces the fixed 2R1W file in the decode/writeback path.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of registers (power of two, >=2)
ADDR_W, 5, register address width (= log2 NREGS)
NRD, 2, number of read ports (>=1)
NWR, 2, number of write ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1: read ports forward same-cycle write data and busy-clear

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  synchronous active-low reset
raddr_i  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata_o  output  NRD*DATA_W  read data, combinational; port k uses bits [k*DATA_W +: DATA_W]
rbusy_o  output  NRD  busy status of each read address, combinational
wen_i  input  NWR  per-port write enable
waddr_i  input  NWR*ADDR_W  write addresses, packed as raddr_i
wdata_i  input  NWR*DATA_W  write data, packed as rdata_o
set_busy_i  input  1  mark set_addr_i pending at next edge
set_addr_i  input  ADDR_W  register to mark busy
busy_o  output  NREGS  full scoreboard vector, bit r = register r pending (registered)

Behaviour:
- Reset is synchronous: rst_n_i low at a rising edge clears all registers to 0 and all busy bits to 0. It overrides same-cycle writes and set_busy_i. Reset mid-operation discards in-flight writes; no partial update occurs.
- After reset: rdata_o = 0 for every address, rbusy_o = 0, busy_o = 0.
- Write: at each rising edge, for each port j with wen_i[j]=1, reg[waddr_i[j]] <= wdata_i[j]. Write latency is 1 cycle.
- Write conflict: when several ports target the same address in one cycle, the highest-index port wins. Lower ports are dropped silently.
- Read: rdata_o[k] = reg[raddr_i[k]], combinational, zero-cycle latency.
- ZERO_REG=1: address 0 always reads 0 and rbusy 0. Writes and set_busy to address 0 are ignored; busy_o[0] stays 0.
- BYPASS=1: if any wen_i[j] matches raddr_i[k] (excluding address 0 when ZERO_REG=1), rdata_o[k] = wdata_i of the highest-index matching port, and rbusy_o[k] = 0 unless set_busy_i targets the same address this cycle.
- BYPASS=0: reads return only the stored value; new data is visible the cycle after the write.
- Scoreboard:
  - Any accepted write to address r clears busy[r] at the edge.
  - set_busy_i sets busy[set_addr_i] at the edge.
  - Set and clear of the same address in the same cycle: set wins (a new producer was issued).
  - Setting an already-busy register leaves it busy.
- rbusy_o[k] = busy[raddr_i[k]], subject to the BYPASS and ZERO_REG rules above.
- Out-of-range addresses (NREGS not a power of two) are illegal; behaviour is undefined, and the bench must not drive them.
- No X propagation: all storage has a defined value after the first reset.

Test Plan:
- Reset then read: rst_n_i=0 for 1 edge, then raddr_i={5,3} -> rdata_o={0,0}, busy_o=0.
- Basic write/read, BYPASS=0: write port0 addr 3 = 0xDEADBEEF; same cycle raddr 3 reads 0; next cycle reads 0xDEADBEEF.
- Conflict plus bypass, BYPASS=1: wen_i=2'b11, both ports addr 7, wdata {0x11,0x22} -> same-cycle read of 7 = 0x22 (port 1); stored value 0x22 after the edge.
- Zero register: write 0xFFFFFFFF to addr 0 and set_busy addr 0 -> reads 0, rbusy 0, busy_o[0]=0 next cycle.
- Scoreboard:
  - set_busy addr 9 -> busy_o[9]=1 next cycle, rbusy for raddr 9 = 1.
  - Then write addr 9 with set_busy addr 9 in the same cycle -> busy_o[9] stays 1.
  - Then write addr 9 alone -> busy_o[9]=0.
- Reset mid-write: registers loaded, then rst_n_i=0 with wen_i=1 addr 4 data 0x55 -> reg 4 = 0 and all busy bits cleared after the edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a per-register busy scoreboard,
// an optional hardwired zero register and optional same-cycle write-to-read bypass.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NRD*ADDR_W-1:0] raddr_i,
    output logic [NRD*DATA_W-1:0] rdata_o,
    output logic [NRD-1:0]        rbusy_o,
    input  logic [NWR-1:0]        wen_i,
    input  logic [NWR*ADDR_W-1:0] waddr_i,
    input  logic [NWR*DATA_W-1:0] wdata_i,
    input  logic                  set_busy_i,
    input  logic [ADDR_W-1:0]     set_addr_i,
    output logic [NREGS-1:0]      busy_o
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] nxt  [NREGS];
    logic [NREGS-1:0]  hit;
    logic [NREGS-1:0]  set_v;
    logic [NREGS-1:0]  busy_q;

    // Later (higher-index) ports overwrite earlier ones, so the highest matching port wins.
    always_comb begin
        hit   = '0;
        set_v = '0;
        for (int r = 0; r < NREGS; r++) begin
            nxt[r] = regs[r];
            for (int j = 0; j < NWR; j++) begin
                if (wen_i[j] && waddr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    nxt[r] = wdata_i[j*DATA_W +: DATA_W];
                    hit[r] = 1'b1;
                end
            end
        end
        set_v[set_addr_i] = set_busy_i;
        if (ZERO_REG != 0) begin
            nxt[0]   = '0;
            hit[0]   = 1'b0;
            set_v[0] = 1'b0;
        end
    end

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= nxt[r];
            busy_q <= (busy_q & ~hit) | set_v;
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            rdata_o[k*DATA_W +: DATA_W] = (BYPASS != 0) ? nxt[raddr_i[k*ADDR_W +: ADDR_W]]
                                                        : regs[raddr_i[k*ADDR_W +: ADDR_W]];
            rbusy_o[k] = (BYPASS != 0 && hit[raddr_i[k*ADDR_W +: ADDR_W]])
                       ? set_v[raddr_i[k*ADDR_W +: ADDR_W]]
                       : busy_q[raddr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    assign busy_o = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench driving three reg_file_mp configurations
// (zero+bypass, zero only, bypass only) against an array-based reference model.
module tb_reg_file_mp;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int NI  = 3;

    typedef struct packed {
        logic                        chk;
        logic [NI-1:0][NRD*DW-1:0]   rd;
        logic [NI-1:0][NRD-1:0]      rb;
        logic [NI-1:0][NR-1:0]       bz;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NWR-1:0]    wen   = '0;
    logic [NWR*AW-1:0] waddr = '0;
    logic [NWR*DW-1:0] wdata = '0;
    logic              sb    = 1'b0;
    logic [AW-1:0]     sa    = '0;
    logic [NRD*DW-1:0] rdata [NI];
    logic [NRD-1:0]    rbusy [NI];
    logic [NR-1:0]     busy  [NI];

    exp_t          q[$];
    exp_t          me;
    logic [DW-1:0] mem [NI][NR];
    logic [NR-1:0] bzm [NI];
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.ZERO_REG(1), .BYPASS(1)) u_zb (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(raddr), .rdata_o(rdata[0]), .rbusy_o(rbusy[0]),
        .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata), .set_busy_i(sb), .set_addr_i(sa),
        .busy_o(busy[0]));
    reg_file_mp #(.ZERO_REG(1), .BYPASS(0)) u_zn (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(raddr), .rdata_o(rdata[1]), .rbusy_o(rbusy[1]),
        .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata), .set_busy_i(sb), .set_addr_i(sa),
        .busy_o(busy[1]));
    reg_file_mp #(.ZERO_REG(0), .BYPASS(1)) u_nb (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(raddr), .rdata_o(rdata[2]), .rbusy_o(rbusy[2]),
        .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata), .set_busy_i(sb), .set_addr_i(sa),
        .busy_o(busy[2]));

    function automatic bit zr(input int i);
        return i != 2;
    endfunction

    function automatic bit byp(input int i);
        return i != 1;
    endfunction

    // Drive one cycle of inputs, queue the expected response, then advance the model past the edge.
    task automatic step(input logic r, input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                        input logic [NWR*DW-1:0] wd, input logic s, input logic [AW-1:0] a,
                        input logic [NRD*AW-1:0] ra, input bit push, input bit chk);
        exp_t          e;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        logic          b;
        logic          h;
        @(posedge clk);
        #1;
        rst_n = r; wen = we; waddr = wa; wdata = wd; sb = s; sa = a; raddr = ra;
        e.chk = chk;
        for (int i = 0; i < NI; i++) begin
            e.bz[i] = bzm[i];
            for (int k = 0; k < NRD; k++) begin
                ad = ra[k*AW +: AW];
                if (zr(i) && ad == 0) begin
                    d = '0;
                    b = 1'b0;
                end else begin
                    d = mem[i][ad];
                    b = bzm[i][ad];
                    h = 1'b0;
                    if (byp(i))
                        for (int j = 0; j < NWR; j++)
                            if (we[j] && wa[j*AW +: AW] == ad) begin
                                d = wd[j*DW +: DW];
                                h = 1'b1;
                            end
                    if (h) b = s && a == ad;
                end
                e.rd[i][k*DW +: DW] = d;
                e.rb[i][k] = b;
            end
        end
        if (push) q.push_back(e);
        for (int i = 0; i < NI; i++) begin
            if (!r) begin
                for (int x = 0; x < NR; x++) mem[i][x] = '0;
                bzm[i] = '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    ad = wa[j*AW +: AW];
                    if (we[j] && !(zr(i) && ad == 0)) begin
                        mem[i][ad] = wd[j*DW +: DW];
                        bzm[i][ad] = 1'b0;
                    end
                end
                if (s && !(zr(i) && a == 0)) bzm[i][a] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            for (int i = 0; i < NI; i++) begin
                tests++;
                if (busy[i] !== me.bz[i]) begin
                    fails++;
                    $display("FAIL busy_o inst%0d: got %h expected %h", i, busy[i], me.bz[i]);
                end
                if (me.chk) begin
                    tests++;
                    if (rdata[i] !== me.rd[i]) begin
                        fails++;
                        $display("FAIL rdata_o inst%0d raddr=%h: got %h expected %h", i, raddr, rdata[i], me.rd[i]);
                    end
                    tests++;
                    if (rbusy[i] !== me.rb[i]) begin
                        fails++;
                        $display("FAIL rbusy_o inst%0d raddr=%h: got %b expected %b", i, raddr, rbusy[i], me.rb[i]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NWR*AW-1:0] wa;
        logic [NRD*AW-1:0] ra;
        step(0, 2'b00, '0, '0, 0, '0, '0, 0, 0);
        step(1, 2'b00, '0, '0, 0, '0, {5'd5, 5'd3}, 1, 1);
        step(1, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEADBEEF}, 0, '0, {5'd3, 5'd3}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd3, 5'd3}, 1, 1);
        step(1, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, 0, '0, {5'd3, 5'd7}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd7, 5'd7}, 1, 1);
        step(1, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 1, 5'd0, {5'd0, 5'd0}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd0, 5'd0}, 1, 1);
        step(1, 2'b00, '0, '0, 1, 5'd9, {5'd9, 5'd9}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd9, 5'd9}, 1, 1);
        step(1, 2'b10, {5'd9, 5'd0}, {32'h99, 32'h0}, 1, 5'd9, {5'd9, 5'd9}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd9, 5'd9}, 1, 1);
        step(1, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h1234}, 0, '0, {5'd9, 5'd9}, 1, 1);
        step(1, 2'b00, '0, '0, 0, '0, {5'd9, 5'd3}, 1, 1);
        step(1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'hAB}, 1, 5'd4, {5'd4, 5'd4}, 1, 1);
        step(0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h55}, 1, 5'd6, {5'd4, 5'd4}, 1, 0);
        step(1, 2'b00, '0, '0, 0, '0, {5'd4, 5'd7}, 1, 1);
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < NWR; j++)
                wa[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NR-1));
            for (int k = 0; k < NRD; k++)
                ra[k*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NR-1));
            step($urandom_range(0, 49) != 0, NWR'($urandom), wa, {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), ra, 1, rst_n !== 1'bx);
        end
        step(1, 2'b00, '0, '0, 0, '0, '0, 0, 0);
        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
